// File: rtl/spi_trng_master_tx_if.sv
// Handshake and SPI pin bundle for spi_trng_master_tx.
// slave = the transmitter block, master = the system-side user.
interface spi_trng_master_tx_if #(
  parameter int DATA_WIDTH = 96
);
  logic                  tx_valid;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_ready;
  logic                  busy;
  logic                  start;
  logic                  ss_n;
  logic                  sclk;
  logic                  mosi;
  logic                  tx_finish;

  modport master (
    output tx_valid,
    output tx_data,
    input  tx_ready,
    input  busy,
    input  start,
    input  ss_n,
    input  sclk,
    input  mosi,
    input  tx_finish
  );

  modport slave (
    input  tx_valid,
    input  tx_data,
    output tx_ready,
    output busy,
    output start,
    output ss_n,
    output sclk,
    output mosi,
    output tx_finish
  );
endinterface

// File: rtl/spi_trng_master_tx.sv
// SPI mode-0 frame transmitter feeding the TRNG-side SPI receiver.
// Define SPI_TRNG_TX_MSB_FIRST_EN for MSB-first bit order (default LSB-first).
module spi_trng_master_tx #(
  parameter int DATA_WIDTH = 96,
  parameter int CLK_DIV    = 4,
  parameter int CNT_W      = 7
) (
  input logic                 clk,
  input logic                 rst_n,
  spi_trng_master_tx_if.slave bus
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_LOW,
    S_HIGH,
    S_TAIL,
    S_DONE
  } state_e;

  state_e                state_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [DATA_WIDTH-1:0] shift_d;
  logic [CNT_W-1:0]      cnt_q;
  logic [DIV_W-1:0]      div_q;
  logic                  start_q;
  logic                  ss_n_q;
  logic                  sclk_q;
  logic                  mosi_q;
  logic                  busy_q;
  logic                  fin_q;
  logic                  div_end;
  logic                  first_bit;
  logic                  next_bit;

  // Shift direction and the bit that goes out next, per bit order.
  always_comb begin
    div_end = (div_q == DIV_LAST);
`ifdef SPI_TRNG_TX_MSB_FIRST_EN
    shift_d   = {shift_q[DATA_WIDTH-2:0], 1'b0};
    next_bit  = shift_q[DATA_WIDTH-2];
    first_bit = bus.tx_data[DATA_WIDTH-1];
`else
    shift_d   = {1'b0, shift_q[DATA_WIDTH-1:1]};
    next_bit  = shift_q[1];
    first_bit = bus.tx_data[0];
`endif
  end

  // Frame sequencer; every pin is a register so the receiver sees clean edges.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      div_q   <= '0;
      start_q <= 1'b0;
      ss_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      fin_q   <= 1'b0;
    end else begin
      start_q <= 1'b0;
      fin_q   <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (bus.tx_valid) begin
            shift_q <= bus.tx_data;
            mosi_q  <= first_bit;
            start_q <= 1'b1;
            ss_n_q  <= 1'b0;
            busy_q  <= 1'b1;
            div_q   <= '0;
            state_q <= S_START;
          end
        end
        S_START: begin
          div_q   <= '0;
          state_q <= S_LOW;
        end
        S_LOW: begin
          if (div_end) begin
            div_q   <= '0;
            sclk_q  <= 1'b1;
            state_q <= S_HIGH;
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        S_HIGH: begin
          if (div_end) begin
            div_q  <= '0;
            sclk_q <= 1'b0;
            if (cnt_q == CNT_LAST) begin
              state_q <= S_TAIL;
            end else begin
              cnt_q   <= cnt_q + 1'b1;
              shift_q <= shift_d;
              mosi_q  <= next_bit;
              state_q <= S_LOW;
            end
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        S_TAIL: begin
          if (div_end) begin
            div_q   <= '0;
            ss_n_q  <= 1'b1;
            fin_q   <= 1'b1;
            mosi_q  <= 1'b0;
            cnt_q   <= '0;
            shift_q <= '0;
            state_q <= S_DONE;
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.tx_ready  = (state_q == S_IDLE);
  assign bus.busy      = busy_q;
  assign bus.start     = start_q;
  assign bus.ss_n      = ss_n_q;
  assign bus.sclk      = sclk_q;
  assign bus.mosi      = mosi_q;
  assign bus.tx_finish = fin_q;

endmodule

// File: tb/tb_spi_trng_master_tx.sv
// Randomized bench for spi_trng_master_tx against a frame-timing model.
// Two instances: CLK_DIV=4 (index 0) and CLK_DIV=2 (index 1).
module tb_spi_trng_master_tx;

  localparam int DW = 96;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rn   [2];
  logic          tv   [2];
  logic [DW-1:0] td   [2];
  logic [6:0]    obs  [2];
  int            cdiv [2] = '{4, 2};
  int            flen [2] = '{774, 388};

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;
  bit hold   = 1'b0;

  bit            mact [2];
  int            mk   [2];
  logic [DW-1:0] mdat [2];

  logic [DW-1:0] rx     [2];
  int            redges [2];
  logic          psclk  [2];

  spi_trng_master_tx_if #(.DATA_WIDTH(DW)) ifa ();
  spi_trng_master_tx_if #(.DATA_WIDTH(DW)) ifb ();

  assign ifa.tx_valid = tv[0];
  assign ifa.tx_data  = td[0];
  assign ifb.tx_valid = tv[1];
  assign ifb.tx_data  = td[1];

  assign obs[0] = {ifa.tx_ready, ifa.busy, ifa.start, ifa.ss_n,
                   ifa.sclk, ifa.mosi, ifa.tx_finish};
  assign obs[1] = {ifb.tx_ready, ifb.busy, ifb.start, ifb.ss_n,
                   ifb.sclk, ifb.mosi, ifb.tx_finish};

  spi_trng_master_tx #(.DATA_WIDTH(DW), .CLK_DIV(4), .CNT_W(7)) dut_a (
    .clk   (clk),
    .rst_n (rn[0]),
    .bus   (ifa)
  );

  spi_trng_master_tx #(.DATA_WIDTH(DW), .CLK_DIV(2), .CNT_W(7)) dut_b (
    .clk   (clk),
    .rst_n (rn[1]),
    .bus   (ifb)
  );

  function automatic logic [DW-1:0] rnd96();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic bitof(logic [DW-1:0] d, int b);
`ifdef SPI_TRNG_TX_MSB_FIRST_EN
    return d[DW-1-b];
`else
    return d[b];
`endif
  endfunction

  // Expected {ready,busy,start,ss_n,sclk,mosi,finish} for cycle k of a frame.
  function automatic logic [6:0] exp_vec(int c, int k, bit a,
                                         logic [DW-1:0] d);
    int sh;
    int j;
    sh = 1 + 2 * c * DW;
    if (!a) return 7'b1001000;
    if (k == 1) return {4'b0110, 1'b0, bitof(d, 0), 1'b0};
    if (k <= sh) begin
      j = k - 2;
      return {4'b0100, ((j % (2 * c)) >= c), bitof(d, j / (2 * c)), 1'b0};
    end
    if (k <= sh + c) return {4'b0100, 1'b0, bitof(d, DW - 1), 1'b0};
    return 7'b0101001;
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] got,
                     input logic [DW-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  // Model: advances the frame cycle index and captures on the handshake.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rn[i]) begin
        mact[i] = 1'b0;
        mk[i]   = 0;
      end else if (mact[i]) begin
        if (mk[i] == 2 + 2 * cdiv[i] * DW + cdiv[i]) mact[i] = 1'b0;
        else mk[i]++;
      end else if (tv[i]) begin
        mact[i] = 1'b1;
        mk[i]   = 1;
        mdat[i] = td[i];
      end
    end
  end

  // Per-cycle compare plus a receiver model sampling on sclk rise.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("pins dut%0d k=%0d", i, mk[i]),
            DW'(obs[i]), DW'(exp_vec(cdiv[i], mk[i], mact[i], mdat[i])));
        if (obs[i][4]) begin
          rx[i]     = '0;
          redges[i] = 0;
          chk($sformatf("start_pos dut%0d", i), DW'(mk[i]), DW'(1));
        end
        if (obs[i][2] && !psclk[i] && !obs[i][3]) begin
          redges[i]++;
`ifdef SPI_TRNG_TX_MSB_FIRST_EN
          rx[i] = {rx[i][DW-2:0], obs[i][1]};
`else
          rx[i] = {obs[i][1], rx[i][DW-1:1]};
`endif
        end
        psclk[i] = obs[i][2];
        if (obs[i][0]) begin
          chk($sformatf("finish_pos dut%0d", i), DW'(mk[i]), DW'(flen[i]));
          chk($sformatf("rise_count dut%0d", i), DW'(redges[i]), DW'(DW));
          chk($sformatf("rx_data dut%0d", i), rx[i], mdat[i]);
        end
      end
    end
  end

  task automatic send(input int i, input logic [DW-1:0] d);
    td[i] = d;
    tv[i] = 1'b1;
    @(posedge clk);
    #2;
    tv[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i);
    int n;
    n = 0;
    @(negedge clk);
    while (mact[i] && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("idle_timeout dut%0d", i), DW'(mact[i]), DW'(0));
    @(posedge clk);
    #2;
  endtask

  initial begin
    #1_000_000;
    bad++;
    $display("FAIL watchdog got=running want=done");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int n;
    int kr;
    for (int i = 0; i < 2; i++) begin
      rn[i]     = 1'b0;
      tv[i]     = 1'b0;
      td[i]     = '0;
      rx[i]     = '0;
      redges[i] = 0;
      psclk[i]  = 1'b0;
    end
    repeat (3) @(posedge clk);
    #2;
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset_pins_a", DW'(obs[0]), DW'(7'b1001000));
    chk("reset_pins_b", DW'(obs[1]), DW'(7'b1001000));
    @(posedge clk);
    #2;
    rn[0] = 1'b1;
    rn[1] = 1'b1;
    repeat (2) @(posedge clk);
    #2;

    fork
      begin
        send(0, 96'h0123_4567_89AB_CDEF_FEDC_BA98);
        wait_idle(0);
      end
      begin
        send(1, {24{4'hA}});
        wait_idle(1);
      end
    join

    td[0] = rnd96();
    tv[0] = 1'b1;
    hold  = 1'b1;
    fork
      while (hold) begin
        @(posedge clk);
        #2;
        td[0] = rnd96();
      end
    join_none
    n = 0;
    @(negedge clk);
    while (!obs[0][0] && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_first_finish", DW'(obs[0][0]), DW'(1));
    @(negedge clk);
    chk("b2b_idle_gap", DW'(obs[0][6]), DW'(1));
    @(negedge clk);
    chk("b2b_second_start", DW'(obs[0][4]), DW'(1));
    tv[0] = 1'b0;
    hold  = 1'b0;
    wait_idle(0);

    kr = 2 + 39 * 2 * cdiv[0] + cdiv[0];
    send(0, rnd96());
    repeat (kr - 1) @(posedge clk);
    #2;
    rn[0] = 1'b0;
    @(posedge clk);
    #2;
    rn[0] = 1'b1;
    @(negedge clk);
    chk("abort_pins", DW'(obs[0]), DW'(7'b1001000));
    @(posedge clk);
    #2;
    send(0, rnd96());
    wait_idle(0);

    for (int r = 0; r < 3; r++) begin
      fork
        begin
          repeat ($urandom_range(0, 5)) @(posedge clk);
          #2;
          send(0, (r == 0) ? 96'h1 : rnd96());
          wait_idle(0);
        end
        begin
          repeat ($urandom_range(0, 5)) @(posedge clk);
          #2;
          send(1, (r == 0) ? {DW{1'b1}} : rnd96());
          wait_idle(1);
        end
      join
    end

    repeat (4) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_trng_master_tx.md
Name: spi_trng_master_tx

Overview:
- SPI transmitter that drives one fixed-length frame into the TRNG-side SPI slave receiver.
- Accepts a DATA_WIDTH-bit word through a valid/ready handshake.
- Generates `start`, `ss_n`, `sclk` and `mosi` in SPI mode 0: sclk idles low; the slave samples on the sclk rising edge, detected in its own clk domain.
- Sits on the system side, opposite the receiver, on the same clk.

Parameters:
- DATA_WIDTH, 96, frame length in bits; the receiver's terminal count is fixed at 96.
- CLK_DIV, 4, clk cycles per sclk half-period; must be >= 2.
- CNT_W, 7, width of the bit counter; must satisfy 2^CNT_W > DATA_WIDTH.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- tx_valid  in  1  tx_data is valid; request to send a frame.
- tx_data  in  DATA_WIDTH  word to transmit.
- tx_ready  out  1  high only in IDLE; the handshake completes when tx_valid && tx_ready.
- busy  out  1  high from the cycle after the handshake until the DONE cycle inclusive.
- start  out  1  one-cycle pulse that arms the receiver.
- ss_n  out  1  active-low slave select.
- sclk  out  1  serial clock, registered.
- mosi  out  1  serial data, registered.
- tx_finish  out  1  one-cycle pulse when the frame is complete.

Behaviour:
- Reset values (any state): state=IDLE, tx_ready=1, busy=0, start=0, ss_n=1, sclk=0, mosi=0, tx_finish=0, shift register=0, bit counter=0, divider=0.
- Reset mid-frame aborts on the next clk edge. No tx_finish is issued. The receiver is responsible for its own recovery.
- All outputs are registered. No combinational path from inputs to outputs, except tx_ready, which is a decode of the state register.
- State machine:
  - IDLE:
    - sclk=0, ss_n=1, mosi=0.
    - On tx_valid: capture tx_data into the shift register and go to START.
  - START (1 cycle):
    - start=1, ss_n=0, sclk=0, mosi=bit 0, divider cleared.
    - Go to LOW.
  - LOW (CLK_DIV cycles):
    - sclk=0, mosi stable.
    - At divider terminal, go to HIGH.
  - HIGH (CLK_DIV cycles):
    - sclk=1.
    - At divider terminal:
      - if bit counter == DATA_WIDTH-1, go to TAIL;
      - else increment the bit counter, shift, present the next bit on mosi (change coincides with sclk falling), and go to LOW.
  - TAIL (CLK_DIV cycles):
    - sclk=0, ss_n held 0, so the receiver sees its last rising edge with ss_n low.
    - Go to DONE.
  - DONE (1 cycle):
    - ss_n=1, tx_finish=1, mosi=0, counter cleared.
    - Go to IDLE.
- Bit order: LSB first (bit 0 on the first rising edge). This matches a receiver that shifts in at the MSB and shifts right.
- Frame length, handshake edge to tx_finish cycle: 1 + 2*CLK_DIV*DATA_WIDTH + CLK_DIV + 1 cycles. Defaults give 774.
- Exactly DATA_WIDTH sclk rising edges per frame. No sclk activity outside START..TAIL.
- tx_valid during busy is ignored. tx_data changes after capture have no effect.
- Back-to-back: if tx_valid is high in the IDLE cycle following DONE, the next frame starts. Minimum ss_n-high gap is 1 cycle (DONE) + 1 cycle (IDLE).
- Bit counter never wraps: terminal compare at DATA_WIDTH-1 precedes increment.

Optional Feature:
- Macro: SPI_TRNG_TX_MSB_FIRST_EN.
- Defined:
  - shift register shifts left; mosi = bit DATA_WIDTH-1 first and bit 0 last;
  - START presents tx_data[DATA_WIDTH-1].
- Undefined: LSB-first as above.
- Frame timing, handshake and all other outputs are identical in both builds.

Test Plan:
- Reset → outputs at reset values. Then tx_data=96'h0123_4567_89AB_CDEF_FEDC_BA98, pulse tx_valid → start high exactly 1 cycle after the handshake, 96 sclk rising edges, tx_finish at cycle 774. The receiver model's data_o equals tx_data in its finish cycle.
- Alternating pattern 96'hAAAA...A with CLK_DIV=2 → mosi toggles each sclk period, first bit 0. Frame length 1+384+2+1=388 cycles. ss_n low from START through TAIL.
- tx_valid held high continuously with different data on each handshake → two frames. Second start occurs 2 cycles after the first tx_finish. tx_data changes during the frame do not alter mosi.
- rst_n low for 1 cycle during the 40th HIGH phase → next cycle sclk=0, ss_n=1, mosi=0, busy=0, tx_ready=1. No tx_finish. A subsequent frame transmits correctly.
- Build with SPI_TRNG_TX_MSB_FIRST_EN, tx_data=96'h1 → mosi low for the first 95 bits and high on the 96th rising edge. The MSB-first receiver model recovers 96'h1.
